// File: rtl/rega_sequenciador_if.sv
// Timer-side bus of the irrigation sequencer: count tick, scan select, per-digit async set/clear, stop flag.
interface rega_sequenciador_if;
  logic       new_clock;
  logic [1:0] seletor;
  logic [3:0] preset_us, preset_ds, preset_um, preset_dm;
  logic [3:0] clear_us, clear_ds, clear_um, clear_dm;
  logic       timer_stop;

  modport master (
    output new_clock, seletor,
    output preset_us, preset_ds, preset_um, preset_dm,
    output clear_us, clear_ds, clear_um, clear_dm,
    input  timer_stop
  );

  modport slave (
    input  new_clock, seletor,
    input  preset_us, preset_ds, preset_um, preset_dm,
    input  clear_us, clear_ds, clear_um, clear_dm,
    output timer_stop
  );
endinterface

// File: rtl/rega_sequenciador.sv
// Irrigation sequencer: loads the MM:SS timer, gates its 1 s tick, drives the valve, enforces cooldown.
// Optional REGA_CICLOS_EN adds a saturating count (ciclos) of runs that ended on timer_stop.
module rega_sequenciador #(
  parameter int          CLK_HZ        = 50_000_000,
  parameter int          SCAN_DIV      = 50_000,
  parameter logic [15:0] GOTA_MMSS     = 16'h0130,
  parameter logic [15:0] ASPERSOR_MMSS = 16'h0500,
  parameter int          COOLDOWN_S    = 10
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                umidade_baixa,
  input  logic                modo,
  input  logic                manual_stop,
  rega_sequenciador_if.master tmr,
  output logic                valvula,
  output logic                ocupado,
  output logic                fim
`ifdef REGA_CICLOS_EN
  ,
  output logic [7:0]          ciclos
`endif
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int CW = $clog2(COOLDOWN_S + 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_S - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  typedef enum logic [2:0] {IDLE, CARGA, ASSENTA, REGA, PAUSA} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc;
  logic [CW-1:0] cool;
  logic [SW-1:0] scan;
  logic [1:0]    seletor_q;
  logic          sec_tick, wrap_q, new_clock_q;
  logic          abort, done;
  logic [15:0]   preset_sel, preset_nx, clear_nx, preset_q, clear_q;

  assign sec_tick = (presc == PRESC_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    abort      = 1'b0;
    done       = 1'b0;
    preset_nx  = 16'hFFFF;
    clear_nx   = 16'hFFFF;
    preset_sel = modo ? ASPERSOR_MMSS : GOTA_MMSS;
    case (state)
      IDLE:    if (!manual_stop && umidade_baixa) state_nx = CARGA;
      CARGA:   state_nx = ASSENTA;
      ASSENTA: state_nx = REGA;
      REGA: begin
        if (manual_stop) begin
          abort    = 1'b1;
          state_nx = PAUSA;
        end else if (tmr.timer_stop) begin
          done     = 1'b1;
          state_nx = PAUSA;
        end
      end
      PAUSA:   if (sec_tick && cool == COOL_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // The mode is captured here: the CARGA load pattern is registered on the IDLE->CARGA edge.
    if (state == IDLE && state_nx == CARGA) begin
      preset_nx = ~preset_sel;
      clear_nx  = preset_sel;
    end
    if (abort) clear_nx = 16'h0000;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc       <= '0;
      cool        <= '0;
      wrap_q      <= 1'b0;
      new_clock_q <= 1'b0;
      preset_q    <= 16'hFFFF;
      clear_q     <= 16'hFFFF;
      valvula     <= 1'b0;
      ocupado     <= 1'b0;
      fim         <= 1'b0;
    end else begin
      // Every state change restarts the second prescaler, so REGA and PAUSA both start at 0.
      if (state_nx != state)                   presc <= '0;
      else if (state == REGA || state == PAUSA) presc <= sec_tick ? '0 : presc + 1'b1;
      if (state != PAUSA)  cool <= '0;
      else if (sec_tick)   cool <= cool + 1'b1;
      wrap_q      <= (state == REGA) && sec_tick && (state_nx == REGA);
      new_clock_q <= wrap_q && (state == REGA) && (state_nx == REGA);
      preset_q    <= preset_nx;
      clear_q     <= clear_nx;
      valvula     <= (state_nx == REGA);
      ocupado     <= (state_nx != IDLE);
      fim         <= done;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan      <= '0;
      seletor_q <= 2'd0;
    end else if (scan == SCAN_MAX) begin
      scan      <= '0;
      seletor_q <= seletor_q + 2'd1;
    end else begin
      scan      <= scan + 1'b1;
    end
  end

`ifdef REGA_CICLOS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     ciclos <= 8'd0;
    else if (done && ciclos != 8'hFF) ciclos <= ciclos + 8'd1;
  end
`endif

  assign tmr.new_clock = new_clock_q;
  assign tmr.seletor   = seletor_q;
  assign tmr.preset_dm = preset_q[15:12];
  assign tmr.preset_um = preset_q[11:8];
  assign tmr.preset_ds = preset_q[7:4];
  assign tmr.preset_us = preset_q[3:0];
  assign tmr.clear_dm  = clear_q[15:12];
  assign tmr.clear_um  = clear_q[11:8];
  assign tmr.clear_ds  = clear_q[7:4];
  assign tmr.clear_us  = clear_q[3:0];
endmodule

// File: tb/tb_rega_sequenciador.sv
// Directed bench for rega_sequenciador with a BCD MM:SS timer model on the timer bus.
module tb_rega_sequenciador;
  logic clock = 1'b0, reset_n = 1'b0;
  logic umidade_baixa = 1'b0, modo = 1'b0, manual_stop = 1'b0;
  logic valvula, ocupado, fim;
`ifdef REGA_CICLOS_EN
  logic [7:0] ciclos;
`endif
  int n_cmp = 0, n_err = 0, ticks = 0;
  logic [15:0] mdl = 16'h0000;
  logic [15:0] pre_bus, clr_bus;

  rega_sequenciador_if tmr();

  always #5 clock = ~clock;

  assign pre_bus = {tmr.preset_dm, tmr.preset_um, tmr.preset_ds, tmr.preset_us};
  assign clr_bus = {tmr.clear_dm, tmr.clear_um, tmr.clear_ds, tmr.clear_us};
  assign tmr.timer_stop = (mdl == 16'h0000);

  rega_sequenciador #(
    .CLK_HZ(10), .SCAN_DIV(4), .GOTA_MMSS(16'h0130), .ASPERSOR_MMSS(16'h0000), .COOLDOWN_S(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .umidade_baixa(umidade_baixa), .modo(modo),
    .manual_stop(manual_stop), .tmr(tmr), .valvula(valvula), .ocupado(ocupado), .fim(fim)
`ifdef REGA_CICLOS_EN
    , .ciclos(ciclos)
`endif
  );

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (r == 16'h0000) return r;
    if (r[3:0] != 4'd0) r[3:0] = r[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (r[7:4] != 4'd0) r[7:4] = r[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (r[11:8] != 4'd0) r[11:8] = r[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd9;
          r[15:12] = r[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Timer digits: async set/clear win over the count tick; they are not touched by reset.
  always @(posedge clock) begin
    if (reset_n === 1'b1) begin
      if (pre_bus != 16'hFFFF || clr_bus != 16'hFFFF) mdl <= (mdl | ~pre_bus) & clr_bus;
      else if (tmr.new_clock === 1'b1)               mdl <= bcd_dec(mdl);
      if (tmr.new_clock === 1'b1) ticks++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      step();
      if (ocupado === 1'b0) break;
    end
    chk(tag, 32'(ocupado), 32'd0);
  endtask

  task automatic run_zero();
    modo = 1'b1; umidade_baixa = 1'b1;
    step();
    umidade_baixa = 1'b0;
    wait_idle("run_zero_idle");
  endtask

  task automatic run_abort();
    modo = 1'b0; umidade_baixa = 1'b1;
    step();
    umidade_baixa = 1'b0;
    step(); step(); step();
    manual_stop = 1'b1;
    step();
    manual_stop = 1'b0;
    wait_idle("run_abort_idle");
  endtask

  initial begin
    int first, last, badgap, cyc, fimcyc, t0;

    repeat (3) step();
    chk("rst_valvula", 32'(valvula), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_fim", 32'(fim), 32'd0);
    chk("rst_new_clock", 32'(tmr.new_clock), 32'd0);
    chk("rst_seletor", 32'(tmr.seletor), 32'd0);
    chk("rst_preset", 32'(pre_bus), 32'h0000FFFF);
    chk("rst_clear", 32'(clr_bus), 32'h0000FFFF);
    reset_n = 1'b1;

    for (int j = 1; j <= 20; j++) begin
      step();
      chk("seletor_scan", 32'(tmr.seletor), 32'((j / 4) % 4));
    end
    chk("idle_valvula", 32'(valvula), 32'd0);
    chk("idle_ocupado", 32'(ocupado), 32'd0);
    chk("idle_preset", 32'(pre_bus), 32'h0000FFFF);

    // Drip run from 01:30
    umidade_baixa = 1'b1; modo = 1'b0;
    step();
    chk("carga_preset_ds", 32'(tmr.preset_ds), 32'hC);
    chk("carga_clear_ds", 32'(tmr.clear_ds), 32'h3);
    chk("carga_preset_um", 32'(tmr.preset_um), 32'hE);
    chk("carga_clear_um", 32'(tmr.clear_um), 32'h1);
    chk("carga_preset_bus", 32'(pre_bus), 32'h0000FECF);
    chk("carga_clear_bus", 32'(clr_bus), 32'h00000130);
    chk("carga_ocupado", 32'(ocupado), 32'd1);
    chk("carga_valvula", 32'(valvula), 32'd0);
    umidade_baixa = 1'b0;
    step();
    chk("assenta_preset", 32'(pre_bus), 32'h0000FFFF);
    chk("assenta_clear", 32'(clr_bus), 32'h0000FFFF);
    chk("assenta_valvula", 32'(valvula), 32'd0);
    step();
    chk("rega_valvula", 32'(valvula), 32'd1);
    chk("rega_new_clock0", 32'(tmr.new_clock), 32'd0);

    first = -1; last = 0; badgap = 0; cyc = 0; fimcyc = -1; t0 = ticks;
    for (int i = 0; i < 1200 && fimcyc < 0; i++) begin
      step();
      cyc++;
      if (tmr.new_clock === 1'b1) begin
        if (first < 0) first = cyc;
        else if (cyc - last != 10) badgap++;
        last = cyc;
      end
      if (fim === 1'b1) fimcyc = cyc;
    end
    chk("first_tick_cycle", 32'(first), 32'd11);
    chk("tick_period_errors", 32'(badgap), 32'd0);
    chk("tick_count", 32'(ticks - t0), 32'd90);
    chk("fim_cycle", 32'(fimcyc), 32'd903);
    chk("fim_valvula", 32'(valvula), 32'd0);
    chk("fim_ocupado", 32'(ocupado), 32'd1);
    step();
    chk("fim_pulse_end", 32'(fim), 32'd0);
    repeat (18) step();
    chk("pausa_still_busy", 32'(ocupado), 32'd1);
    step();
    chk("pausa_to_idle", 32'(ocupado), 32'd0);
    chk("pausa_no_ticks", 32'(ticks - t0), 32'd90);

    // Abort mid-REGA; manual_stop then held through PAUSA and into IDLE
    umidade_baixa = 1'b1; modo = 1'b0;
    step();
    umidade_baixa = 1'b0;
    step(); step();
    repeat (30) step();
    chk("abort_pre_valvula", 32'(valvula), 32'd1);
    manual_stop = 1'b1;
    step();
    chk("abort_clear", 32'(clr_bus), 32'd0);
    chk("abort_preset", 32'(pre_bus), 32'h0000FFFF);
    chk("abort_valvula", 32'(valvula), 32'd0);
    chk("abort_fim", 32'(fim), 32'd0);
    chk("abort_new_clock", 32'(tmr.new_clock), 32'd0);
    step();
    chk("abort_clear_end", 32'(clr_bus), 32'h0000FFFF);
    chk("abort_fim_later", 32'(fim), 32'd0);
    repeat (18) step();
    chk("abort_pausa_busy", 32'(ocupado), 32'd1);
    step();
    chk("abort_to_idle", 32'(ocupado), 32'd0);
    umidade_baixa = 1'b1;
    repeat (3) step();
    chk("stop_priority_idle", 32'(ocupado), 32'd0);
    umidade_baixa = 1'b0; manual_stop = 1'b0;
    step();

    // Zero preset: REGA lasts one cycle, no tick
    modo = 1'b1; umidade_baixa = 1'b1;
    step();
    chk("zero_preset_bus", 32'(pre_bus), 32'h0000FFFF);
    chk("zero_clear_bus", 32'(clr_bus), 32'd0);
    umidade_baixa = 1'b0;
    step();
    chk("zero_timer_stop", 32'(tmr.timer_stop), 32'd1);
    step();
    chk("zero_rega_valvula", 32'(valvula), 32'd1);
    t0 = ticks;
    step();
    chk("zero_fim", 32'(fim), 32'd1);
    chk("zero_valvula_off", 32'(valvula), 32'd0);
    chk("zero_new_clock", 32'(tmr.new_clock), 32'd0);
    step();
    chk("zero_fim_end", 32'(fim), 32'd0);
    chk("zero_no_ticks", 32'(ticks - t0), 32'd0);
    wait_idle("zero_idle");

    // Reset mid-run closes the valve without waiting for a clock edge
    modo = 1'b0; umidade_baixa = 1'b1;
    step();
    umidade_baixa = 1'b0;
    step(); step();
    repeat (5) step();
    chk("midrun_valvula", 32'(valvula), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valvula", 32'(valvula), 32'd0);
    chk("async_rst_ocupado", 32'(ocupado), 32'd0);
    step();
    reset_n = 1'b1;
    step();

`ifdef REGA_CICLOS_EN
    chk("ciclos_reset", 32'(ciclos), 32'd0);
    run_zero(); run_zero(); run_zero();
    run_abort();
    chk("ciclos_three", 32'(ciclos), 32'd3);
    for (int k = 0; k < 297; k++) run_zero();
    chk("ciclos_saturate", 32'(ciclos), 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
